// File: rtl/fifo_single_clock_reg_v4_pkg.sv
// Shared definitions for the single-clock register FIFO.
//   - Read-mode string constants compared against the FWFT_MODE parameter.
//   - inc_ptr : wrapping pointer increment (depth-1 -> 0), depth need not be a power of two.
//   - sat_max : max of two values clamped to a ceiling, used for peak-occupancy tracking.
package fifo_pkg;

    localparam string MODE_FWFT = "TRUE";
    localparam string MODE_STD  = "FALSE";

    function automatic int inc_ptr(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic int sat_max(input int a, input int b, input int ceiling);
        int m;
        m = (a > b) ? a : b;
        return (m > ceiling) ? ceiling : m;
    endfunction

endpackage

// File: rtl/fifo_single_clock_reg_v4_if.sv
// Producer/consumer bus of the single-clock FIFO.
//   master : the surrounding logic (drives flush, writes, reads, clr_err; observes status)
//   slave  : the FIFO itself
// Signals: flush, w_req, w_data, r_req, clr_err  (master -> slave)
//          r_data, r_valid, cnt, empty, full, almost_empty, almost_full,
//          fail, ovf, udf, peak_cnt                (slave -> master)
interface fifo_single_clock_reg_v4_if #(
    parameter int DATA_W  = 32,
    parameter int DEPTH_W = 4
);
    logic               flush;
    logic               w_req;
    logic [DATA_W-1:0]  w_data;
    logic               r_req;
    logic               clr_err;
    logic [DATA_W-1:0]  r_data;
    logic               r_valid;
    logic [DEPTH_W-1:0] cnt;
    logic               empty;
    logic               full;
    logic               almost_empty;
    logic               almost_full;
    logic               fail;
    logic               ovf;
    logic               udf;
    logic [DEPTH_W-1:0] peak_cnt;

    modport master (
        output flush, w_req, w_data, r_req, clr_err,
        input  r_data, r_valid, cnt, empty, full, almost_empty, almost_full,
               fail, ovf, udf, peak_cnt
    );

    modport slave (
        input  flush, w_req, w_data, r_req, clr_err,
        output r_data, r_valid, cnt, empty, full, almost_empty, almost_full,
               fail, ovf, udf, peak_cnt
    );
endinterface

// File: rtl/fifo_single_clock_reg_v4_ptr_wrap.sv
// Wrapping FIFO pointer: counts 0..DEPTH-1 and wraps to 0.
//   clk   : rising-edge clock
//   nrst  : asynchronous active-low reset (pointer -> 0)
//   en_i  : advance the pointer this cycle
//   clr_i : synchronous clear, wins over en_i
//   ptr_o : current pointer value
module fifo_ptr_wrap
    import fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (en_i) begin
            ptr_d = PTR_W'(inc_ptr(int'(ptr_q), DEPTH));
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_single_clock_reg_v4.sv
// Single-clock register FIFO with FWFT or standard (registered) read mode.
//   clk  : rising-edge clock
//   nrst : asynchronous active-low reset
//   bus  : slave side of fifo_single_clock_reg_v4_if
//          flush (sync clear, beats w_req/r_req), w_req/w_data, r_req, clr_err in;
//          r_data, r_valid, cnt, empty, full, almost_empty, almost_full,
//          fail, ovf, udf, peak_cnt out.
module fifo_single_clock_reg_v4
    import fifo_pkg::*;
#(
    parameter string FWFT_MODE = "FALSE",
    parameter int    DEPTH     = 8,
    parameter int    DEPTH_W   = $clog2(DEPTH) + 1,
    parameter int    DATA_W    = 32,
    parameter int    AF_LEVEL  = DEPTH - 2,
    parameter int    AE_LEVEL  = 2
) (
    input logic                     clk,
    input logic                     nrst,
    fifo_single_clock_reg_v4_if.slave bus
);

    // Pointers only need to address DEPTH slots; cnt carries the extra bit for "full".
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit IS_FWFT = (FWFT_MODE == MODE_FWFT);

    localparam logic [DEPTH_W-1:0] DEPTH_C = DEPTH_W'(DEPTH);
    localparam logic [DEPTH_W-1:0] AF_C    = DEPTH_W'(AF_LEVEL);
    localparam logic [DEPTH_W-1:0] AE_C    = DEPTH_W'(AE_LEVEL);

    if (!(DEPTH >= 2 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_param_err
        $error("fifo_single_clock_reg_v4: need DEPTH>=2 and AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]      w_ptr;
    logic [AW-1:0]      r_ptr;
    logic [DEPTH_W-1:0] cnt_q,  cnt_d;
    logic [DEPTH_W-1:0] peak_q, peak_d;
    logic               ovf_q,  ovf_d;
    logic               udf_q,  udf_d;
    logic               empty, full;
    logic               w_acc, r_acc, w_fail, r_fail;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == DEPTH_C);

    // A write into a full FIFO is accepted when a read frees a slot in the same cycle.
    // Flush silences both requests, so nothing is accepted and nothing fails.
    assign w_acc  = ~bus.flush & bus.w_req & (~full | bus.r_req);
    assign r_acc  = ~bus.flush & bus.r_req & ~empty;
    assign w_fail = ~bus.flush & bus.w_req & ~w_acc;
    assign r_fail = ~bus.flush & bus.r_req & ~r_acc;

    fifo_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(AW)) u_w_ptr (
        .clk   (clk),
        .nrst  (nrst),
        .en_i  (w_acc),
        .clr_i (bus.flush),
        .ptr_o (w_ptr)
    );

    fifo_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(AW)) u_r_ptr (
        .clk   (clk),
        .nrst  (nrst),
        .en_i  (r_acc),
        .clr_i (bus.flush),
        .ptr_o (r_ptr)
    );

    // NOTE: the storage array has no reset; empty/cnt gate every read, so stale words are never seen.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            mem_q[w_ptr] <= bus.w_data;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        peak_d = peak_q;
        if (bus.flush) begin
            cnt_d  = '0;
            peak_d = '0;
        end else begin
            cnt_d  = cnt_q + DEPTH_W'(w_acc) - DEPTH_W'(r_acc);
            peak_d = DEPTH_W'(sat_max(int'(cnt_d), int'(peak_q), DEPTH));
        end
        // A failure in the same cycle as clr_err keeps the flag set.
        ovf_d = w_fail | (ovf_q & ~bus.clr_err);
        udf_d = r_fail | (udf_q & ~bus.clr_err);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q  <= '0;
            peak_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            peak_q <= peak_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    if (IS_FWFT) begin : g_fwft
        // Head word shown directly; forced to zero so an empty FIFO never exposes stale storage.
        assign bus.r_data  = empty ? '0 : mem_q[r_ptr];
        assign bus.r_valid = ~empty;
    end else begin : g_std
        logic [DATA_W-1:0] data_buf_q, data_buf_d;
        logic              r_valid_q;

        // data_buf holds the last popped word until the next accepted read.
        always_comb begin
            data_buf_d = data_buf_q;
            if (r_acc) begin
                data_buf_d = mem_q[r_ptr];
            end
        end

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                data_buf_q <= '0;
                r_valid_q  <= 1'b0;
            end else begin
                data_buf_q <= data_buf_d;
                r_valid_q  <= r_acc;
            end
        end

        assign bus.r_data  = data_buf_q;
        assign bus.r_valid = r_valid_q;
    end

    assign bus.cnt          = cnt_q;
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.almost_empty = (cnt_q <= AE_C);
    assign bus.almost_full  = (cnt_q >= AF_C);
    assign bus.fail         = w_fail | r_fail;
    assign bus.ovf          = ovf_q;
    assign bus.udf          = udf_q;
    assign bus.peak_cnt     = peak_q;

endmodule
